// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result and an optional iterative multiplier.
// Define ALU_MUL_EN to build the shift-add multiplier for op 0100; otherwise op 0100 reports Err_o.
module alu_seq #(
    parameter int WIDTH     = 32,
    parameter int IMM_SHIFT = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [3:0]       ALUCtrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o,
    output logic             Err_o
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_ADD  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam int         CW     = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

    state_t           r_state;
    state_t           w_next;
    state_t           w_start;
    logic [WIDTH-1:0] r_data;
    logic             r_err;
    logic             w_accept;
    logic [WIDTH:0]   w_alu;

    // Single-cycle ops; MUL is not decoded here, so it lands in the illegal path.
    function automatic logic [WIDTH:0] alu_eval(input logic [3:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        logic             bad;
        logic [SHW-1:0]   shamt;
        res   = '0;
        bad   = 1'b0;
        shamt = b[SHW-1:0];
        case (op)
            OP_ADDI: res = a + (b >> IMM_SHIFT);
            OP_SUB:  res = a - b;
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            OP_ADD:  res = a + b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            default: bad = 1'b1;
        endcase
        return {bad, res};
    endfunction

    assign w_alu       = alu_eval(ALUCtrl_i, data1_i, data2_i);
    assign w_accept    = in_valid_i & in_ready_o;
    assign out_valid_o = (r_state == S_DONE);
    assign data_o      = r_data;
    assign Zero_o      = (r_data == '0);
    assign Err_o       = r_err;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_mul_last;

    assign w_start    = (ALUCtrl_i == OP_MUL) ? S_MUL : S_DONE;
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));

    // Shift-add multiplier: one multiplier bit per MUL cycle, operands loaded on every accept.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_acc    <= '0;
            r_mcand  <= data1_i;
            r_mplier <= data2_i;
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end
`else
    assign w_start = S_DONE;
`endif

    // Ready is only combinational in DONE, so a result hand-off and a new accept can share an edge.
    always_comb begin
        in_ready_o = 1'b0;
        case (r_state)
            S_IDLE:  in_ready_o = 1'b1;
            S_DONE:  in_ready_o = out_ready_i;
            default: in_ready_o = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = w_start;
                else          w_next = S_IDLE;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                if (w_mul_last) w_next = S_DONE;
                else            w_next = S_MUL;
            end
`endif
            S_DONE: begin
                if (w_accept)         w_next = w_start;
                else if (out_ready_i) w_next = S_IDLE;
                else                  w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State and result registers; the result only changes when a new one is produced.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept && (w_start == S_DONE)) begin
                r_data <= w_alu[WIDTH-1:0];
                r_err  <= w_alu[WIDTH];
            end
`ifdef ALU_MUL_EN
            else if (w_mul_last) begin
                r_data <= w_acc_next;
                r_err  <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed literal cases plus a randomized stream
// compared each cycle against a queue-based behavioural model (honours ALU_MUL_EN).
module tb_alu_seq;
    localparam int W   = 32;
    localparam int IMM = 20;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] data1_i;
    logic [W-1:0] data2_i;
    logic [3:0]   ALUCtrl_i;
    logic         out_valid_o;
    logic         out_ready_i = 1'b1;
    logic [W-1:0] data_o;
    logic         Zero_o;
    logic         Err_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit rnd_rdy = 1'b0;
    bit rdy_val = 1'b1;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           vis;
    } exp_t;
    exp_t q[$];

    alu_seq #(.WIDTH(W), .IMM_SHIFT(IMM)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data1_i(data1_i), .data2_i(data2_i), .ALUCtrl_i(ALUCtrl_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data_o(data_o), .Zero_o(Zero_o), .Err_o(Err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        #2;
        out_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: actual %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    // Spec-level reference: plain arithmetic per op code.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic e);
        logic [63:0] prod;
        r = '0;
        e = 1'b0;
        case (op)
            4'd1:  r = a + (b >> IMM);
            4'd3:  r = a - b;
            4'd4: begin
                if (MUL_EN) begin
                    prod = 64'(a) * 64'(b);
                    r    = prod[W-1:0];
                end else begin
                    e = 1'b1;
                end
            end
            4'd5:  r = a | b;
            4'd6:  r = a & b;
            4'd7:  r = a + b;
            4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  r = a << b[4:0];
            4'd10: r = a >> b[4:0];
            default: e = 1'b1;
        endcase
    endtask

    task automatic mon_step();
        logic         exp_valid;
        logic         exp_ready;
        logic [W-1:0] r;
        logic         e;
        int           lat;
        if (!rst_i) begin
            q.delete();
            return;
        end
        exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
        chk("out_valid", 64'(out_valid_o), 64'(exp_valid));
        if (exp_valid) begin
            chk("data", 64'(data_o), 64'(q[0].res));
            chk("zero", 64'(Zero_o), 64'(q[0].res == '0));
            chk("err", 64'(Err_o), 64'(q[0].err));
        end
        exp_ready = exp_valid ? out_ready_i : (q.size() == 0);
        chk("in_ready", 64'(in_ready_o), 64'(exp_ready));
        if (exp_valid && out_ready_i) void'(q.pop_front());
        if (in_valid_i && exp_ready) begin
            model(ALUCtrl_i, data1_i, data2_i, r, e);
            lat = (MUL_EN && ALUCtrl_i == 4'd4) ? W + 1 : 1;
            q.push_back('{res: r, err: e, vis: cyc + lat});
        end
    endtask

    // Offer one op and return at posedge+1 just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        in_valid_i = 1'b1;
        ALUCtrl_i  = op;
        data1_i    = a;
        data2_i    = b;
        n = 0;
        @(negedge clk_i);
        while (!in_ready_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 300) chk("accept_timeout", 64'(n), 64'(0));
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [W-1:0] r;
        logic         e;
        int           n;
        int           c0;
        logic [3:0]   legal [9] = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
        logic [3:0]   op;

        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        ALUCtrl_i  = 4'd0;
        data1_i    = '0;
        data2_i    = '0;

        fork
            forever begin
                @(negedge clk_i);
                mon_step();
            end
        join_none

        // Pin the model with hand-computed values.
        model(4'd7, 32'd5, 32'd7, r, e);                  chk("m_add", 64'(r), 64'd12);
        model(4'd3, 32'd9, 32'd9, r, e);                  chk("m_sub", 64'(r), 64'd0);
        model(4'd7, 32'hFFFF_FFFF, 32'd1, r, e);          chk("m_wrap", 64'(r), 64'd0);
        model(4'd8, 32'hFFFF_FFFF, 32'd1, r, e);          chk("m_slt", 64'(r), 64'd1);
        model(4'd1, 32'd10, 32'h0030_0000, r, e);         chk("m_addi", 64'(r), 64'd13);
        model(4'd9, 32'd1, 32'd35, r, e);                 chk("m_sll", 64'(r), 64'd8);
        model(4'd15, 32'd1, 32'd1, r, e);                 chk("m_ill", 64'({e, r}), 64'h1_0000_0000);

        #12;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_zero", 64'(Zero_o), 64'd1);
        chk("rst_err", 64'(Err_o), 64'd0);
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        send(4'd7, 32'd5, 32'd7);
        chk("add_valid", 64'(out_valid_o), 64'd1);
        chk("add_data", 64'(data_o), 64'd12);
        chk("add_zero", 64'(Zero_o), 64'd0);
        send(4'd3, 32'd9, 32'd9);
        chk("sub_data", 64'(data_o), 64'd0);
        chk("sub_zero", 64'(Zero_o), 64'd1);
        send(4'd7, 32'hFFFF_FFFF, 32'd1);
        chk("wrap_data", 64'(data_o), 64'd0);
        send(4'd15, 32'd3, 32'd4);
        chk("ill_data", 64'(data_o), 64'd0);
        chk("ill_err", 64'(Err_o), 64'd1);
        send(4'd4, 32'd3, 32'hFFFF_FFFF);
        if (MUL_EN) begin
            n = 1;
            while (!out_valid_o && n < 100) begin
                chk("mul_ready", 64'(in_ready_o), 64'd0);
                @(posedge clk_i); #1;
                n++;
            end
            chk("mul_latency", 64'(n), 64'd33);
            chk("mul_data", 64'(data_o), 64'hFFFF_FFFD);
            chk("mul_err", 64'(Err_o), 64'd0);
        end else begin
            chk("nomul_err", 64'(Err_o), 64'd1);
            chk("nomul_data", 64'(data_o), 64'd0);
        end

        c0 = cyc;
        send(4'd7, 32'hFFFF_FFFF, 32'd1);
        send(4'd5, 32'hFFFF_FFFF, 32'd1);
        send(4'd8, 32'hFFFF_FFFF, 32'd1);
        chk("stream_cycles", 64'(cyc - c0), 64'd3);
        chk("stream_slt", 64'(data_o), 64'd1);
        repeat (2) @(posedge clk_i);
        #1;

        rdy_val = 1'b0;
        send(4'd7, 32'h1234, 32'd1);
        repeat (5) begin
            chk("bp_valid", 64'(out_valid_o), 64'd1);
            chk("bp_data", 64'(data_o), 64'h1235);
            chk("bp_ready", 64'(in_ready_o), 64'd0);
            @(posedge clk_i); #1;
        end
        rdy_val = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        rdy_val = 1'b0;
        send(MUL_EN ? 4'd4 : 4'd7, 32'h0000_1234, 32'h0000_5678);
        repeat (9) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk("rstmid_valid", 64'(out_valid_o), 64'd0);
        chk("rstmid_data", 64'(data_o), 64'd0);
        chk("rstmid_zero", 64'(Zero_o), 64'd1);
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        rdy_val = 1'b1;
        repeat (40) @(posedge clk_i);
        #1;
        chk("rstmid_stale", 64'(out_valid_o), 64'd0);

        rnd_rdy = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk_i); #1;
            end
            if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(0, 15));
            else                            op = legal[$urandom_range(0, 8)];
            send(op, rand_opnd(), rand_opnd());
        end
        rnd_rdy = 1'b0;
        repeat (60) @(posedge clk_i);
        #1;
        chk("drain", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: datapath width in bits, legal range 8..64.
REQ-002 SHALL provide parameter IMM_SHIFT, default 20: right-shift amount applied to data2_i for the ADDI op.
REQ-003 SHALL provide port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL provide port in_valid_i, input, 1 bit: an operation is offered.
REQ-006 SHALL provide port in_ready_o, output, 1 bit: the block accepts an operation this cycle.
REQ-007 SHALL provide port data1_i, input, WIDTH bits: operand A.
REQ-008 SHALL provide port data2_i, input, WIDTH bits: operand B.
REQ-009 SHALL provide port ALUCtrl_i, input, 4 bits: operation code.
REQ-010 SHALL provide port out_valid_o, output, 1 bit: a result is held on the outputs.
REQ-011 SHALL provide port out_ready_i, input, 1 bit: the consumer takes the result.
REQ-012 SHALL provide port data_o, output, WIDTH bits: the result.
REQ-013 SHALL provide port Zero_o, output, 1 bit: data_o equals 0.
REQ-014 SHALL provide port Err_o, output, 1 bit: the op code was illegal or disabled.

Function
REQ-015 Op codes SHALL be:
- 0001 ADDI: A+(B>>IMM_SHIFT)
- 0011 SUB: A-B
- 0100 MUL: low WIDTH bits of A*B
- 0101 OR
- 0110 AND
- 0111 ADD
- 1000 SLT: signed A<B gives 1, else 0
- 1001 SLL: A<<B[log2(WIDTH)-1:0]
- 1010 SRL: logical right shift by the same amount
REQ-016 Add, subtract and ADDI SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-017 Any other op code SHALL produce data_o=0 and Err_o=1 with single-cycle latency; Err_o=0 for every legal op.
REQ-018 Operands and op SHALL be captured only on an accept: the edge where in_valid_i and in_ready_o are both 1.
REQ-019 FSM states SHALL be IDLE, MUL and DONE.
REQ-020 IDLE SHALL move to DONE on accepting a non-MUL op; the result is registered, so out_valid_o=1 one cycle after the accept.
REQ-021 IDLE SHALL move to MUL on accepting op 0100.
REQ-022 MUL SHALL run an iterative shift-add multiply of exactly WIDTH cycles, then enter DONE; out_valid_o rises WIDTH+1 cycles after the accept.
REQ-023 In MUL, in_ready_o SHALL be 0 and out_valid_o SHALL be 0.
REQ-024 In DONE, data_o, Zero_o and Err_o SHALL stay stable until the edge where out_ready_i=1.
REQ-025 In DONE, in_ready_o SHALL equal out_ready_i, allowing a back-to-back accept on the same edge as the result hand-off.
REQ-026 On such a back-to-back accept the FSM SHALL go directly to DONE or MUL with no IDLE bubble, for one result per cycle on non-MUL streams.
REQ-027 In DONE with out_ready_i=1 and in_valid_i=0, the FSM SHALL return to IDLE.
REQ-028 In IDLE, in_ready_o SHALL be 1 and out_valid_o SHALL be 0.
REQ-029 Zero_o SHALL be derived from the registered data_o, never from the inputs.

Reset
REQ-030 rst_i low SHALL, immediately and asynchronously, force:
- state to IDLE
- out_valid_o to 0
- data_o to 0
- Zero_o to 1
- Err_o to 0
- the multiplier accumulator and counter to 0
REQ-031 Reset asserted during MUL or DONE SHALL discard the operation; no result is presented after release.
REQ-032 On the first rising edge after rst_i returns high, in_ready_o SHALL be 1.

Configuration
REQ-033 With ALU_MUL_EN defined, op 0100 SHALL behave per REQ-021 and REQ-022.
REQ-034 Without ALU_MUL_EN, the MUL state and multiplier hardware SHALL be absent, and op 0100 SHALL be treated as illegal per REQ-017.

Verification
REQ-035 WIDTH=32, ADD A=5, B=7, out_ready_i=1 -> data_o=12, Zero_o=0, out_valid_o one cycle after the accept.
REQ-036 SUB A=9, B=9 -> data_o=0, Zero_o=1; ADD A=FFFFFFFF, B=1 -> data_o=0 (wrap).
REQ-037 ALU_MUL_EN, MUL A=3, B=FFFFFFFF -> data_o=FFFFFFFD after 33 cycles; in_ready_o=0 throughout the MUL state.
REQ-038 Stream of ADD, OR, SLT (A=FFFFFFFF, B=1) with out_ready_i held 1 -> results on three consecutive cycles, last data_o=1.
REQ-039 out_ready_i held 0 for 5 cycles in DONE -> data_o stable and in_ready_o=0; op 1111 -> data_o=0, Err_o=1; without ALU_MUL_EN, op 0100 -> Err_o=1.
REQ-040 rst_i pulsed low at cycle 10 of a MUL -> out_valid_o=0 and data_o=0 immediately; no stale result after release.
